// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: memory, redirect and decode-side signals of the fetch unit
interface instr_fetch_unit_if #(parameter int DATA_W = 32);
    logic              imem_req;
    logic [DATA_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [DATA_W-1:0] redirect_pc;
    logic              if_valid;
    logic              if_ready;
    logic [DATA_W-1:0] if_instr;
    logic [DATA_W-1:0] if_pc;
    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
    );
    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: credit-limited instruction prefetcher with in-order response buffer and redirect flush
module instr_fetch_unit #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_PC  = '0,
    parameter int                BUF_DEPTH = 2
) (
    input logic                clk,
    input logic                reset,
    instr_fetch_unit_if.master bus
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_L = BUF_DEPTH[CW:0];
    localparam logic [DATA_W-1:0] RST_PC = {RESET_PC[DATA_W-1:2], 2'b00};

    typedef enum logic {IDLE, REQ} state_t;
    state_t state, state_n;

    logic [DATA_W-1:0] fetch_pc, fetch_pc_n, pend_pc, rtgt;
    logic              redir_pend, redir_pend_n;
    logic [CW-1:0]     live, disc, buf_cnt, live_a, disc_a, live_n, disc_n, buf_n;
    logic [CW:0]       tot, occ_n, tot_n;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic              af_rd, af_wr;
    logic [DATA_W-1:0] buf_instr [BUF_DEPTH];
    logic [DATA_W-1:0] buf_pc [BUF_DEPTH];
    logic [DATA_W-1:0] af_pc [2];
    logic              redirect, gnt, gnt_disc, rv_acc, rv_live, push, pop, credit;

    assign redirect      = bus.redirect_valid;
    assign rtgt          = {bus.redirect_pc[DATA_W-1:2], 2'b00};
    assign bus.imem_req  = state == REQ;
    assign bus.imem_addr = {fetch_pc[DATA_W-1:2], 2'b00};
    assign bus.if_valid  = buf_cnt != '0;
    assign bus.if_instr  = bus.if_valid ? buf_instr[rd_ptr] : '0;
    assign bus.if_pc     = bus.if_valid ? buf_pc[rd_ptr] : '0;

    // Discards always drain first: responses return in request order.
    always_comb begin
        gnt          = bus.imem_req & bus.imem_gnt;
        gnt_disc     = gnt & (redirect | redir_pend);
        tot          = {1'b0, live} + {1'b0, disc};
        rv_acc       = bus.imem_rvalid & (tot != '0);
        rv_live      = rv_acc & (disc == '0);
        push         = rv_live & ~redirect;
        pop          = bus.if_valid & bus.if_ready;
        live_a       = live + CW'(gnt & ~gnt_disc) - CW'(rv_live);
        disc_a       = disc + CW'(gnt_disc) - CW'(rv_acc & (disc != '0));
        live_n       = redirect ? '0 : live_a;
        disc_n       = redirect ? disc_a + live_a : disc_a;
        buf_n        = redirect ? '0 : buf_cnt + CW'(push) - CW'(pop);
        occ_n        = {1'b0, buf_n} + {1'b0, live_n};
        tot_n        = {1'b0, live_n} + {1'b0, disc_n};
        credit       = (occ_n < DEPTH_L) & ~|tot_n[CW:1];
        state_n      = (state == IDLE || gnt) ? (credit ? REQ : IDLE) : state;
        fetch_pc_n   = (redirect && (state == IDLE || gnt)) ? rtgt :
                       gnt ? (redir_pend ? pend_pc : fetch_pc + DATA_W'(4)) : fetch_pc;
        redir_pend_n = gnt ? 1'b0 : (redirect && state == REQ) ? 1'b1 : redir_pend;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            fetch_pc   <= RST_PC;
            pend_pc    <= '0;
            redir_pend <= 1'b0;
            live       <= '0;
            disc       <= '0;
            buf_cnt    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            af_rd      <= 1'b0;
            af_wr      <= 1'b0;
        end else begin
            state      <= state_n;
            fetch_pc   <= fetch_pc_n;
            pend_pc    <= redirect ? rtgt : pend_pc;
            redir_pend <= redir_pend_n;
            live       <= live_n;
            disc       <= disc_n;
            buf_cnt    <= buf_n;
            wr_ptr     <= wr_ptr + PW'(push);
            rd_ptr     <= redirect ? wr_ptr : rd_ptr + PW'(pop);
            af_wr      <= af_wr ^ gnt;
            af_rd      <= af_rd ^ rv_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= bus.imem_rdata;
            buf_pc[wr_ptr]    <= af_pc[af_rd];
        end
        if (gnt) af_pc[af_wr] <= bus.imem_addr;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios with a scripted memory and decode stage
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.DATA_W(32)) bus ();
    instr_fetch_unit_if #(.DATA_W(32)) bus2 ();

    instr_fetch_unit #(.DATA_W(32), .RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    instr_fetch_unit #(.DATA_W(32), .RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit gnt_on, rv_on, rdy, b2_rv;
    logic [31:0] rq[$], gnt_log[$], pc_log[$], cyc_log[$], gnt_log2[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One cycle: drive at the falling edge, observe, then run through the rising edge.
    task automatic tick(input bit redir = 1'b0, input logic [31:0] rpc = '0);
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.imem_gnt       = gnt_on;
        bus.if_ready       = rdy;
        if (rv_on && rq.size() > 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = instr_of(rq.pop_front());
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
        end
        bus2.imem_gnt       = 1'b1;
        bus2.imem_rvalid    = b2_rv;
        bus2.imem_rdata     = '0;
        bus2.if_ready       = 1'b1;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;
        #1;
        if (bus.imem_req && gnt_on) begin
            rq.push_back(bus.imem_addr);
            gnt_log.push_back(bus.imem_addr);
        end
        if (bus.if_valid && rdy) begin
            pc_log.push_back(bus.if_pc);
            cyc_log.push_back(32'(cyc));
            check("if_instr", bus.if_instr, instr_of(bus.if_pc));
        end
        b2_rv = bus2.imem_req;
        if (bus2.imem_req) gnt_log2.push_back(bus2.imem_addr);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        gnt_on = 1'b0;
        rv_on  = 1'b0;
        rdy    = 1'b0;
        #1;
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_valid", 32'(bus.if_valid), 32'd0);
        check("rst_instr", bus.if_instr, 32'h0);
        check("rst_pc", bus.if_pc, 32'h0);
        check("rst_addr2", bus2.imem_addr, 32'hFFFF_FFF8);
        repeat (2) tick();
        rq.delete();
        gnt_log.delete();
        pc_log.delete();
        cyc_log.delete();
        gnt_log2.delete();
        b2_rv = 1'b0;
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        // Streaming with gnt tied high and immediate decode acceptance
        do_reset();
        gnt_on = 1'b1; rv_on = 1'b1; rdy = 1'b1;
        repeat (12) tick();
        check("t1_cyc0", at(cyc_log, 0), 32'd3);
        check("t1_pc0", at(pc_log, 0), 32'h0);
        check("t1_cyc1", at(cyc_log, 1), 32'd4);
        check("t1_pc1", at(pc_log, 1), 32'h4);
        check("t1_pc2", at(pc_log, 2), 32'h8);
        check("t1_gnt2", at(gnt_log, 2), 32'h8);
        check("wrap_a0", at(gnt_log2, 0), 32'hFFFF_FFF8);
        check("wrap_a1", at(gnt_log2, 1), 32'hFFFF_FFFC);
        check("wrap_a2", at(gnt_log2, 2), 32'h0000_0000);

        // Decode stalled: buffer fills and requesting stops
        do_reset();
        gnt_on = 1'b1; rv_on = 1'b1; rdy = 1'b0;
        repeat (10) tick();
        check("t2_ngnt", 32'(gnt_log.size()), 32'd2);
        check("t2_req", 32'(bus.imem_req), 32'd0);
        check("t2_valid", 32'(bus.if_valid), 32'd1);
        check("t2_head", bus.if_pc, 32'h0);
        rdy = 1'b1;
        repeat (6) tick();
        check("t2_pc0", at(pc_log, 0), 32'h0);
        check("t2_pc1", at(pc_log, 1), 32'h4);
        check("t2_gnt2", at(gnt_log, 2), 32'h8);

        // Redirect while a request waits for grant
        do_reset();
        gnt_on = 1'b0; rv_on = 1'b1; rdy = 1'b1;
        repeat (2) tick();
        tick(1'b1, 32'h100);
        repeat (2) tick();
        check("t3_req_held", 32'(bus.imem_req), 32'd1);
        check("t3_addr_held", bus.imem_addr, 32'h0);
        gnt_on = 1'b1;
        repeat (8) tick();
        check("t3_gnt0", at(gnt_log, 0), 32'h0);
        check("t3_gnt1", at(gnt_log, 1), 32'h100);
        check("t3_pc0", at(pc_log, 0), 32'h100);

        // Redirect with two responses in flight
        do_reset();
        gnt_on = 1'b1; rv_on = 1'b0; rdy = 1'b1;
        repeat (3) tick();
        check("t4_ngnt", 32'(gnt_log.size()), 32'd2);
        tick(1'b1, 32'h203);
        check("t4_addr", bus.imem_addr, 32'h200);
        rv_on = 1'b1;
        repeat (8) tick();
        check("t4_gnt2", at(gnt_log, 2), 32'h200);
        check("t4_pc0", at(pc_log, 0), 32'h200);
        check("t4_pc1", at(pc_log, 1), 32'h204);

        // Reset mid-fetch with one request outstanding; its late response must be ignored
        do_reset();
        gnt_on = 1'b1; rv_on = 1'b0; rdy = 1'b1;
        repeat (2) tick();
        gnt_on = 1'b0;
        tick();
        check("t5_pending", 32'(rq.size()), 32'd1);
        do_reset();
        rq.push_back(32'hBAD0_0000);
        gnt_on = 1'b1; rv_on = 1'b1; rdy = 1'b1;
        repeat (8) tick();
        check("t5_gnt0", at(gnt_log, 0), 32'h0);
        check("t5_pc0", at(pc_log, 0), 32'h0);
        check("t5_cyc0", at(cyc_log, 0), 32'd3);
        check("t5_pc1", at(pc_log, 1), 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
